ex_muldiv_unit: RTL and testbench



---
 rtl/riscv_m_pkg.sv | 58 +++++
 rtl/ex_muldiv_unit_if.sv | 30 +++
 rtl/muldiv_iter_core.sv | 98 +++++++++
 rtl/ex_muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_m_pkg.sv
// Shared definitions for the RV64M execute-stage multiply/divide unit.
//   XLEN          datapath width (64 only)
//   F3_*          M-extension func3 encodings
//   ITER_D/ITER_W iteration counts for 64-bit and word ops
//   state_e       control FSM states
//   mdu_result    sign fix-up, result select and word extension
package riscv_m_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int unsigned ITER_D = 64;
    localparam int unsigned ITER_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Turns unsigned magnitude results back into the architectural result.
    // neg1/neg2 are the operand signs captured at launch (0 for unsigned operands).
    function automatic logic [XLEN-1:0] mdu_result(
        input logic [2:0]        f3,
        input logic              word,
        input logic              neg1,
        input logic              neg2,
        input logic [2*XLEN-1:0] prod,
        input logic [XLEN-1:0]   quot,
        input logic [XLEN-1:0]   rem
    );
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q;
        logic [XLEN-1:0]   rm;
        logic [XLEN-1:0]   r;
        p  = (neg1 ^ neg2) ? -prod : prod;
        q  = (neg1 ^ neg2) ? -quot : quot;
        rm = neg1 ? -rem : rem;
        if (f3[2]) begin
            r = f3[1] ? rm : q;
        end else begin
            r = (f3 == F3_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
        end
        if (word) begin
            r = {{32{r[31]}}, r[31:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Execute-stage handshake between the EX control path and the M-extension unit.
//   start_i/kill_i   launch / abort from the pipeline
//   func3_i/word_i   decoded M-op and OP-32 flag
//   rs1_i/rs2_i      forwarded operands
//   stall_o/done_o   hold request to the hazard unit / result valid
//   result_o         64-bit result
// master: pipeline side; slave: the multiply/divide unit.
interface ex_muldiv_unit_if;

    logic                           start_i;
    logic                           kill_i;
    logic [2:0]                     func3_i;
    logic                           word_i;
    logic [riscv_m_pkg::XLEN-1:0]   rs1_i;
    logic [riscv_m_pkg::XLEN-1:0]   rs2_i;
    logic                           stall_o;
    logic                           done_o;
    logic [riscv_m_pkg::XLEN-1:0]   result_o;

    modport master (
        output start_i, kill_i, func3_i, word_i, rs1_i, rs2_i,
        input  stall_o, done_o, result_o
    );

    modport slave (
        input  start_i, kill_i, func3_i, word_i, rs1_i, rs2_i,
        output stall_o, done_o, result_o
    );

endinterface

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath on unsigned magnitudes: shift-add multiply and
// restoring divide sharing one register set.
//   clk, reset        clock, asynchronous active-high reset
//   load_i            capture operands and clear the iteration count
//   step_i            perform one iteration
//   is_div_i, word_i  operation class and 32-iteration mode (sampled on load_i)
//   op_a_i, op_b_i    multiplicand/dividend, multiplier/divisor magnitudes
//   last_o            the current step is the final iteration
//   prod_o, quot_o, rem_o  results including the current step (valid with last_o)
module muldiv_iter_core
    import riscv_m_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic              word_i,
    input  logic [XLEN-1:0]   op_a_i,
    input  logic [XLEN-1:0]   op_b_i,
    output logic              last_o,
    output logic [2*XLEN-1:0] prod_o,
    output logic [XLEN-1:0]   quot_o,
    output logic [XLEN-1:0]   rem_o
);

    // hi: partial-product high half / partial remainder
    // lo: multiplier shifting out / dividend shifting out, quotient shifting in
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] m_q, m_d;
    logic [6:0]      cnt_q, cnt_d;
    logic            div_q, div_d;
    logic            word_q, word_d;

    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   sh;
    logic [XLEN-1:0] diff;
    logic            ge;

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        word_d  = word_q;
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        sh      = {hi_q, lo_q[XLEN-1]};
        ge      = (sh >= {1'b0, m_q});
        // Wraps correctly whenever ge holds, since the true difference is below m_q.
        diff    = sh[XLEN-1:0] - m_q;

        if (load_i) begin
            hi_d   = '0;
            // Word divides pre-align the dividend so the MSB always feeds the shift.
            lo_d   = is_div_i ? (word_i ? {op_a_i[31:0], 32'b0} : op_a_i) : op_b_i;
            m_d    = is_div_i ? op_b_i : op_a_i;
            cnt_d  = '0;
            div_d  = is_div_i;
            word_d = word_i;
        end else if (step_i) begin
            if (div_q) begin
                hi_d = ge ? diff : sh[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], ge};
            end else begin
                hi_d = add_sum[XLEN:1];
                lo_d = {add_sum[0], lo_q[XLEN-1:1]};
            end
            cnt_d = cnt_q + 7'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
            word_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            word_q <= word_d;
        end
    end

    assign last_o = (cnt_q == (word_q ? 7'(ITER_W - 1) : 7'(ITER_D - 1)));
    // After 32 steps the 64-bit word product sits 32 bits up in {hi, lo}.
    assign prod_o = word_q ? {32'b0, hi_d, lo_d[XLEN-1:32]} : {hi_d, lo_d};
    assign quot_o = lo_d;
    assign rem_o  = hi_d;

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV64M multiply/divide unit in the Execute stage. Holds the instruction in EX
// via stall_o until the iterative core finishes, then presents result_o with a
// one-cycle done_o. Divide-by-zero and signed overflow finish in one cycle.
//   clk, reset   clock, asynchronous active-high reset
//   bus          ex_muldiv_unit_if.slave: start/kill/func3/word/rs1/rs2 in,
//                stall/done/result out
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle combinational
// multiplier; divides stay iterative.
module ex_muldiv_unit
    import riscv_m_pkg::*;
#(
    parameter int unsigned XLEN = riscv_m_pkg::XLEN
) (
    input  logic                clk,
    input  logic                reset,
    ex_muldiv_unit_if.slave     bus
);

    if (XLEN != 64) begin : g_xlen_check
        $error("ex_muldiv_unit supports XLEN=64 only");
    end

    state_e state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [2:0]      func3_q;
    logic            word_q, neg1_q, neg2_q;

    logic            s1_signed, s2_signed, is_div, launch;
    logic            neg1, neg2, div0, ovf, special;
    logic [XLEN-1:0] op1, op2, mag1, mag2, dividend, special_res;
    logic            core_load, core_step, core_last;
    logic [2*XLEN-1:0] core_prod;
    logic [XLEN-1:0] core_quot, core_rem, iter_res;
    logic            stall;

    // Operand conditioning and special-case detection for the launch cycle.
    always_comb begin
        s1_signed = (bus.func3_i == F3_MULH) || (bus.func3_i == F3_MULHSU) ||
                    (bus.func3_i == F3_DIV)  || (bus.func3_i == F3_REM);
        s2_signed = (bus.func3_i == F3_MULH) || (bus.func3_i == F3_DIV) ||
                    (bus.func3_i == F3_REM);
        if (bus.word_i) begin
            op1 = s1_signed ? {{32{bus.rs1_i[31]}}, bus.rs1_i[31:0]} : {32'b0, bus.rs1_i[31:0]};
            op2 = s2_signed ? {{32{bus.rs2_i[31]}}, bus.rs2_i[31:0]} : {32'b0, bus.rs2_i[31:0]};
            dividend = {{32{bus.rs1_i[31]}}, bus.rs1_i[31:0]};
        end else begin
            op1 = bus.rs1_i;
            op2 = bus.rs2_i;
            dividend = bus.rs1_i;
        end
        neg1   = s1_signed & op1[XLEN-1];
        neg2   = s2_signed & op2[XLEN-1];
        mag1   = neg1 ? -op1 : op1;
        mag2   = neg2 ? -op2 : op2;
        is_div = bus.func3_i[2];
        div0   = is_div && (op2 == '0);
        // Signed DIV/REM only (func3[0]=0); op1 is already sign-extended for word ops.
        ovf    = is_div && !bus.func3_i[0] && (op2 == '1) &&
                 (op1 == (bus.word_i ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        if (div0) begin
            special_res = bus.func3_i[1] ? dividend : '1;
        end else begin
            special_res = bus.func3_i[1] ? '0 : dividend;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_res;
    assign fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
    assign fast_res  = mdu_result(bus.func3_i, bus.word_i, neg1, neg2, fast_prod, '0, '0);
    assign special   = div0 | ovf | !is_div;
    logic [XLEN-1:0] launch_res;
    assign launch_res = is_div ? special_res : fast_res;
`else
    assign special = div0 | ovf;
    logic [XLEN-1:0] launch_res;
    assign launch_res = special_res;
`endif

    muldiv_iter_core u_core (
        .clk      (clk),
        .reset    (reset),
        .load_i   (core_load),
        .step_i   (core_step),
        .is_div_i (is_div),
        .word_i   (bus.word_i),
        .op_a_i   (mag1),
        .op_b_i   (mag2),
        .last_o   (core_last),
        .prod_o   (core_prod),
        .quot_o   (core_quot),
        .rem_o    (core_rem)
    );

    assign iter_res = mdu_result(func3_q, word_q, neg1_q, neg2_q, core_prod, core_quot, core_rem);

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        core_load = 1'b0;
        core_step = 1'b0;
        launch    = 1'b0;
        stall     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start_i && !bus.kill_i) begin
                    stall  = 1'b1;
                    launch = 1'b1;
                    if (special) begin
                        state_d  = StDone;
                        result_d = launch_res;
                    end else begin
                        state_d   = StRun;
                        core_load = 1'b1;
                    end
                end
            end
            StRun: begin
                stall = 1'b1;
                if (bus.kill_i) begin
                    state_d = StIdle;
                end else begin
                    core_step = 1'b1;
                    if (core_last) begin
                        state_d  = StDone;
                        result_d = iter_res;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            result_q <= '0;
            func3_q  <= '0;
            word_q   <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (launch) begin
                func3_q <= bus.func3_i;
                word_q  <= bus.word_i;
                neg1_q  <= neg1;
                neg2_q  <= neg2;
            end
        end
    end

    assign bus.stall_o  = stall;
    assign bus.done_o   = (state_q == StDone);
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed cases, kill, reset, back-to-back
// and randomized ops checked against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;
    import riscv_m_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FastMul = 1'b1;
`else
    localparam bit FastMul = 1'b0;
`endif

    localparam logic [63:0] Min64 = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_muldiv_unit_if bus ();

    ex_muldiv_unit #(.XLEN(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;
    logic [63:0] last_exp = '0;

    typedef struct packed {
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
    } vec_t;

    localparam int NDir = 15;
    vec_t dir_tbl [0:NDir-1] = '{
        '{F3_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB},
        '{F3_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFE},
        '{F3_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0},
        '{F3_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF},
        '{F3_DIVU,   1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF},
        '{F3_REMU,   1'b0, 64'd100, 64'd0, 64'd100},
        '{F3_DIV,    1'b0, Min64, 64'hFFFF_FFFF_FFFF_FFFF, Min64},
        '{F3_REM,    1'b0, Min64, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0},
        '{F3_DIV,    1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD},
        '{F3_REM,    1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF},
        '{F3_DIVU,   1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000},
        '{F3_REMU,   1'b1, 64'h1234_5678_8000_0005, 64'hABCD_0000_0000_0000,
          64'hFFFF_FFFF_8000_0005},
        '{F3_DIV,    1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000},
        '{F3_REM,    1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'h0},
        '{F3_DIVU,   1'b0, 64'd1000, 64'd7, 64'd142}
    };

    // Reference model: straight from the RV64M definitions.
    function automatic logic [63:0] ref_result(input logic [2:0] f3, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] ps;
        logic [127:0] pu;
        logic [31:0]  a32, b32, r32;
        logic [63:0]  r;
        r = '0; r32 = '0; a32 = a[31:0]; b32 = b[31:0];
        if (!w) begin
            case (f3)
                F3_MUL:    r = a * b;
                F3_MULH: begin
                    ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
                    r = ps[127:64];
                end
                F3_MULHSU: begin
                    ps = $signed({{64{a[63]}}, a}) * $signed({64'b0, b});
                    r = ps[127:64];
                end
                F3_MULHU: begin
                    pu = {64'b0, a} * {64'b0, b};
                    r = pu[127:64];
                end
                F3_DIV: begin
                    if (b == 0) r = '1;
                    else if (a == Min64 && b == '1) r = a;
                    else r = $signed(a) / $signed(b);
                end
                F3_DIVU: begin
                    if (b == 0) r = '1;
                    else r = a / b;
                end
                F3_REM: begin
                    if (b == 0) r = a;
                    else if (a == Min64 && b == '1) r = '0;
                    else r = $signed(a) % $signed(b);
                end
                default: begin
                    if (b == 0) r = a;
                    else r = a % b;
                end
            endcase
        end else begin
            case (f3)
                F3_MUL: r32 = a32 * b32;
                F3_DIV: begin
                    if (b32 == 0) r32 = '1;
                    else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
                    else r32 = $signed(a32) / $signed(b32);
                end
                F3_DIVU: begin
                    if (b32 == 0) r32 = '1;
                    else r32 = a32 / b32;
                end
                F3_REM: begin
                    if (b32 == 0) r32 = a32;
                    else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
                    else r32 = $signed(a32) % $signed(b32);
                end
                F3_REMU: begin
                    if (b32 == 0) r32 = a32;
                    else r32 = a32 % b32;
                end
                default: r32 = '0;
            endcase
            r = {{32{r32[31]}}, r32};
        end
        return r;
    endfunction

    // Expected cycle of done_o (start cycle = 0); stall_o is high for that many cycles.
    function automatic int exp_lat(input logic [2:0] f3, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        logic b0, ov;
        b0 = w ? (b[31:0] == 0) : (b == 0);
        ov = (f3 == F3_DIV || f3 == F3_REM) &&
             (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                : (a == Min64 && b == '1));
        if (f3[2] && (b0 || ov)) return 1;
        if (!f3[2] && FastMul) return 1;
        return w ? 33 : 65;
    endfunction

    function automatic logic [63:0] rand_op(input logic w);
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: if (w) v[31:0] = '0; else v = '0;
            1: if (w) v[31:0] = '1; else v = '1;
            2: if (w) v[31:0] = 32'h8000_0000; else v = Min64;
            3: if (w) v[31:0] = 32'($urandom_range(0, 15)); else v = 64'($urandom_range(0, 15));
            default: ;
        endcase
        return v;
    endfunction

    // Called at a negedge: presents a launch for the coming posedge.
    task automatic drive(input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
        bus.start_i = 1'b1;
        bus.func3_i = f3;
        bus.word_i  = w;
        bus.rs1_i   = a;
        bus.rs2_i   = b;
    endtask

    // Called right after a launch is driven; counts stall cycles and finds done_o.
    task automatic wait_done(output logic [63:0] res, output int lat, output int stalls);
        res = '0; lat = -1; stalls = 0;
        #1;
        if (bus.stall_o) stalls++;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) begin
                bus.start_i = 1'b0;
                bus.rs1_i   = {$urandom, $urandom};
                bus.rs2_i   = {$urandom, $urandom};
            end
            #1;
            if (bus.stall_o) stalls++;
            if (bus.done_o) begin
                lat = c;
                res = bus.result_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (bus.done_o !== 1'b0) begin
            n_miss++; $display("FAIL reset_done: got %b expected 0", bus.done_o);
        end
        n_vec++;
        if (bus.result_o !== 64'h0) begin
            n_miss++; $display("FAIL reset_result: got %h expected 0", bus.result_o);
        end
        n_vec++;
        if (bus.stall_o !== 1'b0) begin
            n_miss++; $display("FAIL reset_stall: got %b expected 0", bus.stall_o);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [63:0] res;
        int lat, st, el;
        for (int i = 0; i < NDir; i++) begin
            @(negedge clk);
            drive(dir_tbl[i].f3, dir_tbl[i].w, dir_tbl[i].a, dir_tbl[i].b);
            wait_done(res, lat, st);
            el = exp_lat(dir_tbl[i].f3, dir_tbl[i].w, dir_tbl[i].a, dir_tbl[i].b);
            n_vec++;
            if (res !== dir_tbl[i].r) begin
                n_miss++;
                $display("FAIL directed[%0d] result: got %h expected %h", i, res, dir_tbl[i].r);
            end
            n_vec++;
            if (lat != el) begin
                n_miss++; $display("FAIL directed[%0d] done_cycle: got %0d expected %0d", i, lat, el);
            end
            n_vec++;
            if (st != el) begin
                n_miss++; $display("FAIL directed[%0d] stall_cycles: got %0d expected %0d", i, st, el);
            end
            last_exp = dir_tbl[i].r;
        end
    endtask

    task automatic test_kill();
        logic [63:0] res;
        int lat, st;
        logic bad_done, bad_res;
        // Kill in IDLE suppresses launch.
        @(negedge clk);
        drive(F3_DIV, 1'b0, 64'd999, 64'd3);
        bus.kill_i = 1'b1;
        #1;
        n_vec++;
        if (bus.stall_o !== 1'b0) begin
            n_miss++; $display("FAIL kill_idle_stall: got %b expected 0", bus.stall_o);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        #1;
        n_vec++;
        if (bus.stall_o !== 1'b0 || bus.done_o !== 1'b0) begin
            n_miss++;
            $display("FAIL kill_idle_launch: got stall=%b done=%b expected 0/0",
                     bus.stall_o, bus.done_o);
        end
        // Kill in RUN at cycle 10.
        @(negedge clk);
        drive(F3_DIV, 1'b0, 64'd123456789, 64'd1000);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) bus.start_i = 1'b0;
        end
        bus.kill_i = 1'b1;
        #1;
        n_vec++;
        if (bus.stall_o !== 1'b1) begin
            n_miss++; $display("FAIL kill_run_c10_stall: got %b expected 1", bus.stall_o);
        end
        @(posedge clk);
        @(negedge clk);
        bus.kill_i = 1'b0;
        #1;
        n_vec++;
        if (bus.stall_o !== 1'b0) begin
            n_miss++; $display("FAIL kill_run_c11_stall: got %b expected 0", bus.stall_o);
        end
        bad_done = 1'b0;
        bad_res  = 1'b0;
        for (int c = 0; c < 70; c++) begin
            if (bus.done_o !== 1'b0) bad_done = 1'b1;
            if (bus.result_o !== last_exp) bad_res = 1'b1;
            @(negedge clk);
            #1;
        end
        n_vec++;
        if (bad_done) begin
            n_miss++; $display("FAIL kill_no_done: got done=1 expected 0");
        end
        n_vec++;
        if (bad_res) begin
            n_miss++; $display("FAIL kill_result_held: got %h expected %h", bus.result_o, last_exp);
        end
        drive(F3_MUL, 1'b0, 64'd3, 64'd5);
        wait_done(res, lat, st);
        n_vec++;
        if (res !== 64'd15) begin
            n_miss++; $display("FAIL kill_then_mul: got %h expected %h", res, 64'd15);
        end
        n_vec++;
        if (lat != exp_lat(F3_MUL, 1'b0, 64'd3, 64'd5)) begin
            n_miss++; $display("FAIL kill_then_mul_cycle: got %0d expected %0d",
                               lat, exp_lat(F3_MUL, 1'b0, 64'd3, 64'd5));
        end
        last_exp = 64'd15;
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b, c, d, res, e;
        int lat, st;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        c = {$urandom, $urandom};
        d = {32'b0, $urandom} | 64'd1;
        @(negedge clk);
        drive(F3_MUL, 1'b0, a, b);
        wait_done(res, lat, st);
        e = ref_result(F3_MUL, 1'b0, a, b);
        n_vec++;
        if (res !== e) begin
            n_miss++; $display("FAIL b2b_mul: got %h expected %h", res, e);
        end
        // Second op presented in the DONE cycle; it must wait for the following IDLE.
        drive(F3_DIV, 1'b0, c, d);
        #1;
        n_vec++;
        if (bus.stall_o !== 1'b0) begin
            n_miss++; $display("FAIL b2b_done_stall: got %b expected 0", bus.stall_o);
        end
        @(posedge clk);
        @(negedge clk);
        wait_done(res, lat, st);
        e = ref_result(F3_DIV, 1'b0, c, d);
        n_vec++;
        if (res !== e) begin
            n_miss++; $display("FAIL b2b_div: got %h expected %h", res, e);
        end
        n_vec++;
        if (lat != exp_lat(F3_DIV, 1'b0, c, d) || st != lat) begin
            n_miss++; $display("FAIL b2b_div_timing: got done=%0d stalls=%0d expected %0d",
                               lat, st, exp_lat(F3_DIV, 1'b0, c, d));
        end
        last_exp = e;
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a, b, res, e;
        int lat, st, el;
        for (int i = 0; i < 40; i++) begin
            w = ($urandom_range(0, 3) == 0);
            if (w) begin
                case ($urandom_range(0, 4))
                    0: f3 = F3_MUL;
                    1: f3 = F3_DIV;
                    2: f3 = F3_DIVU;
                    3: f3 = F3_REM;
                    default: f3 = F3_REMU;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            a = rand_op(w);
            b = rand_op(w);
            @(negedge clk);
            drive(f3, w, a, b);
            wait_done(res, lat, st);
            e  = ref_result(f3, w, a, b);
            el = exp_lat(f3, w, a, b);
            n_vec++;
            if (res !== e) begin
                n_miss++;
                $display("FAIL random[%0d] f3=%0d w=%0b a=%h b=%h: got %h expected %h",
                         i, f3, w, a, b, res, e);
            end
            n_vec++;
            if (lat != el || st != el) begin
                n_miss++;
                $display("FAIL random[%0d] timing: got done=%0d stalls=%0d expected %0d",
                         i, lat, st, el);
            end
            last_exp = e;
        end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] res;
        int lat, st;
        @(negedge clk);
        drive(F3_DIVU, 1'b0, 64'hFFFF_0000_1234_5678, 64'd77);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) bus.start_i = 1'b0;
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (bus.done_o !== 1'b0 || bus.stall_o !== 1'b0) begin
            n_miss++; $display("FAIL reset_mid_run_state: got done=%b stall=%b expected 0/0",
                               bus.done_o, bus.stall_o);
        end
        n_vec++;
        if (bus.result_o !== 64'h0) begin
            n_miss++; $display("FAIL reset_mid_run_result: got %h expected 0", bus.result_o);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        drive(F3_MUL, 1'b0, 64'd3, 64'd5);
        wait_done(res, lat, st);
        n_vec++;
        if (res !== 64'd15) begin
            n_miss++; $display("FAIL reset_then_mul: got %h expected %h", res, 64'd15);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        bus.func3_i = '0;
        bus.word_i  = 1'b0;
        bus.rs1_i   = '0;
        bus.rs2_i   = '0;
        test_reset();
        test_directed();
        test_kill();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
